// File: rtl/hash_mem_arbiter.sv
// hash_mem_arbiter
// Round-robin arbiter that lets NUM_REQ hash cores share one single-port,
// word-addressed memory with a 1-cycle synchronous read. At most one access
// is issued per cycle, and the read data is returned to the core that owns
// the grant. A core can hold the grant across a multi-word burst by raising
// its lock bit.
//
// Optional feature: define ARB_LOCK_TIMEOUT_EN to limit how long a core may
// hold a lock. After MAX_LOCK consecutive held cycles the grant is taken
// away, lock_err[core] is set and stays set, and the core is skipped by the
// arbiter until it drops lock. Without the macro a lock is held for as long
// as the core keeps it, and lock_err is tied to zero.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   req/lock/we  [NUM_REQ]   per-core request, grant hold, write enable
//   addr, wdata              per-core address and write data; core i uses
//                            slice [i*W +: W]
//   gnt          [NUM_REQ]   registered one-hot grant, zero when idle
//   rvalid       [NUM_REQ]   registered read-return strobe
//   rdata        [DATA_W]    memory read data, broadcast to all cores
//   mem_we, mem_addr, mem_write_data, mem_read_data   memory port
//   lock_err     [NUM_REQ]   sticky lock-timeout flag
module hash_mem_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_write_data,
    input  logic [DATA_W-1:0]         mem_read_data,
    output logic [NUM_REQ-1:0]        lock_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t               state_r, state_s;
    // owner_r is also the round-robin pointer: in IDLE it keeps the last owner.
    logic [IDX_W-1:0]     owner_r, owner_s;
    logic [NUM_REQ-1:0]   gnt_r, gnt_s;
    logic [NUM_REQ-1:0]   rvalid_r, rvalid_s;
    logic [NUM_REQ-1:0]   arb_req_s;
    logic                 hold_s;
    logic                 found_s;
    logic [IDX_W-1:0]     sel_s;
    logic [IDX_W-1:0]     idx_s;
    logic                 issue_s;

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic [CNT_W-1:0]     hold_cnt_r, hold_cnt_s;
    logic [NUM_REQ-1:0]   blocked_r, blocked_s;
    logic [NUM_REQ-1:0]   lock_err_r, lock_err_s;
    logic                 expire_s;

    // Lock hold accounting: expiry, sticky error and per-core blocking.
    always_comb begin
        expire_s   = 1'b0;
        hold_s     = 1'b0;
        hold_cnt_s = {CNT_W{1'b0}};
        lock_err_s = lock_err_r;
        // A blocked core stays blocked only while it keeps lock raised.
        blocked_s  = blocked_r & lock;
        if ((state_r == OWNED) && lock[owner_r]) begin
            if (hold_cnt_r == CNT_W'(MAX_LOCK - 1)) begin
                // Last permitted held cycle: release at this edge.
                expire_s            = 1'b1;
                lock_err_s[owner_r] = 1'b1;
                blocked_s[owner_r]  = 1'b1;
            end else begin
                hold_s     = 1'b1;
                hold_cnt_s = hold_cnt_r + CNT_W'(1);
            end
        end else begin
            hold_cnt_s = {CNT_W{1'b0}};
        end
        arb_req_s = req & ~blocked_s;
    end

    // Hold counter, blocking mask and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_r <= {CNT_W{1'b0}};
            blocked_r  <= {NUM_REQ{1'b0}};
            lock_err_r <= {NUM_REQ{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_s;
            blocked_r  <= blocked_s;
            lock_err_r <= lock_err_s;
        end
    end

    assign lock_err = lock_err_r;
`else
    // Without the timeout, a raised lock holds the grant indefinitely.
    always_comb begin
        hold_s    = (state_r == OWNED) && lock[owner_r];
        arb_req_s = req;
    end

    assign lock_err = {NUM_REQ{1'b0}};
`endif

    // Next owner: first eligible requester after the pointer, pointer itself last.
    always_comb begin
        found_s = 1'b0;
        sel_s   = owner_r;
        idx_s   = owner_r;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = IDX_W'((int'(owner_r) + k) % NUM_REQ);
            if (!found_s && arb_req_s[idx_s]) begin
                found_s = 1'b1;
                sel_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end

        state_s = state_r;
        owner_s = owner_r;
        if (hold_s) begin
            state_s = OWNED;
            owner_s = owner_r;
        end else if (found_s) begin
            state_s = OWNED;
            owner_s = sel_s;
        end else begin
            state_s = IDLE;
            owner_s = owner_r;
        end

        if (state_s == OWNED) begin
            gnt_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_s;
        end else begin
            gnt_s = {NUM_REQ{1'b0}};
        end
    end

    // Memory access issue, gated by the owner actually requesting this cycle.
    always_comb begin
        issue_s = gnt_r[owner_r] & req[owner_r];
        if (issue_s) begin
            mem_we         = we[owner_r];
            mem_addr       = addr[int'(owner_r)*ADDR_W +: ADDR_W];
            mem_write_data = wdata[int'(owner_r)*DATA_W +: DATA_W];
        end else begin
            mem_we         = 1'b0;
            mem_addr       = {ADDR_W{1'b0}};
            mem_write_data = {DATA_W{1'b0}};
        end
        rvalid_s = gnt_r & req & ~we;
    end

    // Arbiter state, pointer, grant and read-return registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            owner_r  <= IDX_W'(NUM_REQ - 1);
            gnt_r    <= {NUM_REQ{1'b0}};
            rvalid_r <= {NUM_REQ{1'b0}};
        end else begin
            state_r  <= state_s;
            owner_r  <= owner_s;
            gnt_r    <= gnt_s;
            rvalid_r <= rvalid_s;
        end
    end

    assign gnt    = gnt_r;
    assign rvalid = rvalid_r;
    assign rdata  = mem_read_data;

endmodule
